// File: rtl/dma_rd_sched_pkg.sv
// Shared widths and helpers for the DMA read-command scheduler slice.
package dma_rd_sched_pkg;

  localparam int ID_WIDTH            = 4;
  localparam int ADDR_WIDTH          = 32;
  localparam int DMA_SIZE_WIDTH      = 12;
  localparam int DMA_BURST_CNT_WIDTH = DMA_SIZE_WIDTH - 7;

  // One extra counter bit so an all-ones size yields 2^(W-8) without wrapping.
  function automatic logic [DMA_BURST_CNT_WIDTH-1:0] burst_count(input logic [DMA_SIZE_WIDTH-1:0] sz);
    return {1'b0, sz[DMA_SIZE_WIDTH-1:8]} + DMA_BURST_CNT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/dma_rd_sched_if.sv
// Channel descriptor, engine command and AR-observation signals of the scheduler.
interface dma_rd_sched_if
  import dma_rd_sched_pkg::*;
#(
  parameter int NUM_CH = 4
) ();

  localparam int CH_IDX_W = $clog2(NUM_CH);

  logic                               enable;
  logic [NUM_CH-1:0]                  ch_req;
  logic [NUM_CH*ID_WIDTH-1:0]         ch_id;
  logic [NUM_CH*ADDR_WIDTH-1:0]       ch_addr;
  logic [NUM_CH*DMA_SIZE_WIDTH-1:0]   ch_size;
  logic [NUM_CH-1:0]                  ch_grant;
  logic [NUM_CH-1:0]                  ch_done;
  logic                               start;
  logic [ID_WIDTH-1:0]                src_id;
  logic [ADDR_WIDTH-1:0]              src_addr;
  logic [DMA_SIZE_WIDTH-1:0]          size;
  logic                               ar_valid;
  logic                               ar_ready;
  logic                               busy;
  logic [CH_IDX_W-1:0]                cur_ch;

  modport master (
    output enable, ch_req, ch_id, ch_addr, ch_size, ar_valid, ar_ready,
    input  ch_grant, ch_done, start, src_id, src_addr, size, busy, cur_ch
  );

  modport slave (
    input  enable, ch_req, ch_id, ch_addr, ch_size, ar_valid, ar_ready,
    output ch_grant, ch_done, start, src_id, src_addr, size, busy, cur_ch
  );

endinterface

// File: rtl/dma_rr_arb.sv
// Combinational round-robin picker: first requester at or after rr_ptr wins.
module dma_rr_arb #(
  parameter  int NUM_CH = 4,
  localparam int IDX_W  = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  output logic [NUM_CH-1:0] grant,
  output logic [IDX_W-1:0]  idx
);

  logic [IDX_W:0] cand;
  logic           found;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int off = 0; off < NUM_CH; off++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(off);
      if (cand >= (IDX_W+1)'(NUM_CH)) cand = cand - (IDX_W+1)'(NUM_CH);
      if (!found && req[cand[IDX_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[IDX_W-1:0];
      end
    end
    if (found) grant = NUM_CH'(1) << idx;
  end

endmodule

// File: rtl/dma_rd_sched.sv
// Shares one DMA read-command engine among NUM_CH channels, one descriptor at a time,
// counting AR handshakes to detect job completion.
module dma_rd_sched
  import dma_rd_sched_pkg::*;
#(
  parameter int NUM_CH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dma_rd_sched_if.slave bus
);

  localparam int                 CH_IDX_W = $clog2(NUM_CH);
  localparam logic [CH_IDX_W-1:0] LAST_CH = CH_IDX_W'(NUM_CH-1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_START = 2'd1, S_RUN = 2'd2} state_t;

  state_t                         state, state_nx;
  logic [CH_IDX_W-1:0]            rr_ptr, rr_ptr_nx;
  logic [CH_IDX_W-1:0]            cur_ch, cur_ch_nx;
  logic [CH_IDX_W-1:0]            arb_idx;
  logic [NUM_CH-1:0]              arb_gnt;
  logic [NUM_CH-1:0]              grant_q, grant_nx;
  logic [NUM_CH-1:0]              done_q, done_nx;
  logic                           start_q, start_nx;
  logic                           busy_q;
  logic [ID_WIDTH-1:0]            src_id_q, src_id_nx;
  logic [ADDR_WIDTH-1:0]          src_addr_q, src_addr_nx;
  logic [DMA_SIZE_WIDTH-1:0]      size_q, size_nx;
  logic [DMA_BURST_CNT_WIDTH-1:0] burst_cnt, burst_cnt_nx;
  logic                           ar_hs;

  assign ar_hs = bus.ar_valid && bus.ar_ready;

  dma_rr_arb #(.NUM_CH(NUM_CH)) u_arb (
    .req    (bus.ch_req),
    .rr_ptr (rr_ptr),
    .grant  (arb_gnt),
    .idx    (arb_idx)
  );

  // Every output is computed one cycle ahead here and flopped below.
  always_comb begin
    state_nx     = state;
    rr_ptr_nx    = rr_ptr;
    cur_ch_nx    = cur_ch;
    src_id_nx    = src_id_q;
    src_addr_nx  = src_addr_q;
    size_nx      = size_q;
    burst_cnt_nx = burst_cnt;
    start_nx     = 1'b0;
    grant_nx     = '0;
    done_nx      = '0;
    case (state)
      S_IDLE: begin
        if (bus.enable && (|bus.ch_req)) begin
          state_nx    = S_START;
          cur_ch_nx   = arb_idx;
          src_id_nx   = bus.ch_id[arb_idx*ID_WIDTH +: ID_WIDTH];
          src_addr_nx = bus.ch_addr[arb_idx*ADDR_WIDTH +: ADDR_WIDTH];
          size_nx     = bus.ch_size[arb_idx*DMA_SIZE_WIDTH +: DMA_SIZE_WIDTH];
          start_nx    = 1'b1;
          grant_nx    = arb_gnt;
        end
      end
      S_START: begin
        state_nx     = S_RUN;
        burst_cnt_nx = burst_count(size_q);
      end
      S_RUN: begin
        // Handshakes outside RUN are protocol violations and are ignored.
        if (ar_hs) begin
          burst_cnt_nx = burst_cnt - 1'b1;
          if (burst_cnt == DMA_BURST_CNT_WIDTH'(1)) begin
            done_nx   = NUM_CH'(1) << cur_ch;
            rr_ptr_nx = (cur_ch == LAST_CH) ? '0 : cur_ch + 1'b1;
            state_nx  = S_IDLE;
          end
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      cur_ch     <= '0;
      src_id_q   <= '0;
      src_addr_q <= '0;
      size_q     <= '0;
      burst_cnt  <= '0;
      start_q    <= 1'b0;
      grant_q    <= '0;
      done_q     <= '0;
      busy_q     <= 1'b0;
    end else begin
      state      <= state_nx;
      rr_ptr     <= rr_ptr_nx;
      cur_ch     <= cur_ch_nx;
      src_id_q   <= src_id_nx;
      src_addr_q <= src_addr_nx;
      size_q     <= size_nx;
      burst_cnt  <= burst_cnt_nx;
      start_q    <= start_nx;
      grant_q    <= grant_nx;
      done_q     <= done_nx;
      busy_q     <= (state_nx != S_IDLE);
    end
  end

  assign bus.start    = start_q;
  assign bus.ch_grant = grant_q;
  assign bus.ch_done  = done_q;
  assign bus.busy     = busy_q;
  assign bus.cur_ch   = cur_ch;
  assign bus.src_id   = src_id_q;
  assign bus.src_addr = src_addr_q;
  assign bus.size     = size_q;

endmodule
